// File: rtl/misr_sig_engine_if.sv
// Bundle of the control, data and result signals of misr_sig_engine.
//   master: drives start/mode/seed/num_cycles/exp_sig/d_valid/d_in/unload,
//           observes sig/busy/done/pass/so.
//   slave : the engine itself.
interface misr_sig_engine_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] seed;
  logic [CNT_W-1:0] num_cycles;
  logic [WIDTH-1:0] exp_sig;
  logic             d_valid;
  logic [WIDTH-1:0] d_in;
  logic             unload;
  logic [WIDTH-1:0] sig;
  logic             busy;
  logic             done;
  logic             pass;
  logic             so;

  modport master (
    output start, mode, seed, num_cycles, exp_sig, d_valid, d_in, unload,
    input  sig, busy, done, pass, so
  );
  modport slave (
    input  start, mode, seed, num_cycles, exp_sig, d_valid, d_in, unload,
    output sig, busy, done, pass, so
  );
endinterface

// File: rtl/misr_sig_engine.sv
// MISR / LFSR signature engine for BIST wrappers.
// Compacts WIDTH-bit response words into a signature (mode 0) or free-runs
// as an LFSR pattern source (mode 1) for a programmed number of updates,
// compares the result with an expected signature and can shift it out
// serially, MSB first.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-low reset
//   bus  - misr_sig_engine_if.slave: start/mode/seed/num_cycles/exp_sig,
//          d_valid/d_in data, unload request; sig/busy/done/pass/so results
module misr_sig_engine #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(16'h1021),
  parameter int               CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  misr_sig_engine_if.slave  bus
);
  localparam int SH_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] exp_q;
  logic [CNT_W-1:0] cnt;
  logic [SH_W-1:0]  sh_cnt;
  logic             mode_q;
  logic             done_q;
  logic             pass_q;
  logic             so_q;
  logic             adv;
  logic [WIDTH-1:0] nxt;

  // Shift-left Galois update; response word folded in only in MISR mode.
  always_comb begin
    adv = mode_q | bus.d_valid;
    nxt = {sig_q[WIDTH-2:0], 1'b0}
        ^ (sig_q[WIDTH-1] ? POLY : '0)
        ^ (mode_q ? '0 : bus.d_in);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      sig_q  <= '0;
      exp_q  <= '0;
      cnt    <= '0;
      sh_cnt <= '0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      so_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // start wins over unload when both are presented in DONE
          if (bus.start) begin
            sig_q  <= bus.seed;
            cnt    <= bus.num_cycles;
            mode_q <= bus.mode;
            exp_q  <= bus.exp_sig;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            state  <= RUN;
          end else if (state == DONE && bus.unload) begin
            sh_cnt <= SH_W'(WIDTH);
            done_q <= 1'b0;
            state  <= SHIFT;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            // zero-length run: signature stays at the seed
            state  <= DONE;
            done_q <= 1'b1;
            pass_q <= (sig_q == exp_q);
          end else if (adv) begin
            sig_q <= nxt;
            cnt   <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              // compare against the value being written, not the stale one
              state  <= DONE;
              done_q <= 1'b1;
              pass_q <= (nxt == exp_q);
            end
          end
        end
        SHIFT: begin
          so_q   <= sig_q[WIDTH-1];
          sig_q  <= {sig_q[WIDTH-2:0], 1'b0};
          sh_cnt <= sh_cnt - SH_W'(1);
          if (sh_cnt == SH_W'(1)) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sig  = sig_q;
  assign bus.busy = (state == RUN) || (state == SHIFT);
  assign bus.done = done_q;
  assign bus.pass = pass_q;
  assign bus.so   = so_q;
endmodule

// File: tb/tb_misr_sig_engine.sv
// Scoreboard bench for misr_sig_engine (WIDTH=4, POLY=0011, CNT_W=8).
// Stimulus computes each run's outcome with a polynomial model and queues it;
// a negedge monitor pops an entry on every rising edge of done.
module tb_misr_sig_engine;
  localparam int W  = 4;
  localparam int CW = 8;
  localparam logic [W-1:0] P = 4'b0011;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  misr_sig_engine_if #(.WIDTH(W), .CNT_W(CW)) bus();
  misr_sig_engine #(.WIDTH(W), .POLY(P), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W-1:0] sig;
    logic         pass;
    logic         unl;
    logic [W-1:0] bits;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  exp_t         me;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           t_start = 0;
  logic [W-1:0] m_sig = '0;
  logic         m_pass = 1'b0;
  logic         done_d = 1'b0;
  logic [W-1:0] so_hist = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // multiply by x modulo x^W + POLY, then add the data word (GF(2))
  function automatic logic [W-1:0] step(input logic [W-1:0] s, input logic [W-1:0] d);
    int v;
    v = int'(s) << 1;
    if ((v & (1 << W)) != 0) v = v ^ ((1 << W) | int'(P));
    return W'(v) ^ d;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    so_hist = {so_hist[W-2:0], bus.so};
    if (rst && bus.done && !done_d) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected no completion (t=%0t)", $time);
      end else begin
        me = sb.pop_front();
        chk("final_sig", bus.sig, me.sig);
        chk("pass", bus.pass, me.pass);
        chk("latency", cyc - t_start, me.lat);
        if (me.unl) chk("so_stream", so_hist, me.bits);
      end
    end
    done_d = bus.done;
  end

  task automatic wait_sb();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic md, input logic [W-1:0] sd, input int n,
                     input logic [W-1:0] ex_in, input bit force_match, input bit rnd,
                     input logic [15:0] pat, input int din, input bit with_unl);
    logic         dv[$];
    logic [W-1:0] dd[$];
    logic [W-1:0] s, s2, ex, d;
    logic         v;
    int           adv;
    exp_t         e;
    s = sd; adv = 0;
    for (int i = 0; adv < n; i++) begin
      v = rnd ? ($urandom_range(0, 2) != 0) : ((i < 16) ? pat[i] : 1'b1);
      d = (din < 0) ? W'($urandom) : W'(din);
      dv.push_back(v); dd.push_back(d);
      if (md || v) begin s = step(s, md ? '0 : d); adv++; end
    end
    ex = force_match ? s : ex_in;
    e.sig = s; e.pass = (s == ex); e.unl = 1'b0; e.bits = '0;
    e.lat = (n == 0) ? 1 : dv.size();
    sb.push_back(e);
    m_sig = s; m_pass = e.pass;

    bus.start = 1'b1; bus.mode = md; bus.seed = sd; bus.num_cycles = CW'(n);
    bus.exp_sig = ex; bus.unload = with_unl; bus.d_valid = 1'b1; bus.d_in = W'($urandom);
    @(posedge clk); #1;
    t_start = cyc;
    bus.start = 1'b0; bus.unload = 1'b0; bus.mode = ~md;
    bus.seed = W'($urandom); bus.exp_sig = W'($urandom); bus.num_cycles = CW'($urandom);
    if (with_unl) begin
      chk("restart_done_clr", bus.done, 1'b0);
      chk("restart_busy", bus.busy, 1'b1);
    end
    s2 = sd;
    for (int i = 0; i < dv.size(); i++) begin
      bus.d_valid = dv[i]; bus.d_in = dd[i];
      bus.start = rnd && ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      if (md || dv[i]) s2 = step(s2, md ? '0 : dd[i]);
      chk("step_sig", bus.sig, s2);
    end
    bus.start = 1'b0; bus.d_valid = 1'b0;
    wait_sb();
  endtask

  task automatic unload_t();
    exp_t e;
    e.sig = '0; e.pass = m_pass; e.unl = 1'b1; e.bits = m_sig; e.lat = W;
    sb.push_back(e);
    bus.unload = 1'b1;
    @(posedge clk); #1;
    t_start = cyc;
    bus.unload = 1'b0;
    chk("shift_busy", bus.busy, 1'b1);
    for (int k = 1; k < W; k++) begin
      bus.start = ($urandom_range(0, 1) == 1); bus.unload = 1'b1;
      @(posedge clk); #1;
      chk("shift_busy", bus.busy, 1'b1);
    end
    bus.start = 1'b0; bus.unload = 1'b0;
    wait_sb();
    chk("post_shift_busy", bus.busy, 1'b0);
    m_sig = '0;
  endtask

  task automatic reset_mid_run();
    logic [W-1:0] s, d;
    s = W'($urandom);
    bus.start = 1'b1; bus.mode = 1'b0; bus.seed = s; bus.num_cycles = CW'(4);
    bus.exp_sig = '0; bus.d_valid = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      d = W'($urandom);
      bus.d_valid = 1'b1; bus.d_in = d;
      bus.start = (k == 1); bus.seed = ~s; bus.mode = 1'b1;
      @(posedge clk); #1;
      s = step(s, d);
      chk("run_start_ignored", bus.sig, s);
      chk("run_busy", bus.busy, 1'b1);
      chk("run_done_low", bus.done, 1'b0);
    end
    bus.start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; bus.d_valid = 1'b0;
    chk("rst_sig", bus.sig, '0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_pass", bus.pass, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_so", bus.so, 1'b0);
    m_sig = '0; m_pass = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.mode = 1'b0; bus.seed = '0; bus.num_cycles = '0;
    bus.exp_sig = '0; bus.d_valid = 1'b0; bus.d_in = '0; bus.unload = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sig", bus.sig, '0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_pass", bus.pass, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_so", bus.so, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;

    // LFSR full period back to the seed
    run(1'b1, 4'b0001, 15, 4'b0001, 1'b0, 1'b0, 16'hFFFF, -1, 1'b0);
    chk("lfsr_final", bus.sig, 4'b0001);
    // MISR compaction, no gaps
    run(1'b0, 4'b0000, 3, 4'b1001, 1'b0, 1'b0, 16'hFFFF, 3, 1'b0);
    chk("misr_final", bus.sig, 4'b1001);
    chk("misr_busy_after", bus.busy, 1'b0);
    // valid gaps 1,0,0,1,0,1 with a wrong expected signature
    run(1'b0, 4'b0000, 3, 4'b1000, 1'b0, 1'b0, 16'h0029, 3, 1'b0);
    chk("gap_pass", bus.pass, 1'b0);
    // serial unload of 1001
    unload_t();
    chk("unload_sig", bus.sig, '0);
    // zero count, then start together with unload restarts
    run(1'b0, 4'b0101, 0, 4'b0101, 1'b0, 1'b0, 16'hFFFF, -1, 1'b0);
    chk("zero_sig", bus.sig, 4'b0101);
    run(1'b0, W'($urandom), 5, '0, 1'b1, 1'b1, 16'hFFFF, -1, 1'b1);
    // reset in the middle of a run, then a clean run from IDLE
    reset_mid_run();
    run(1'b1, 4'b1010, 7, W'($urandom), 1'b0, 1'b1, 16'hFFFF, -1, 1'b0);

    for (int r = 0; r < 40; r++) begin
      run(1'($urandom_range(0, 1)), W'($urandom), int'($urandom_range(0, 12)),
          W'($urandom), 1'($urandom_range(0, 1)), 1'b1, 16'hFFFF, -1,
          ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 2) == 0) unload_t();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/misr_sig_engine.md
Name: misr_sig_engine

Overview:
- Parametrised multiple-input signature register (MISR) with a built-in LFSR pattern-generator mode, cycle-count control, signature compare and serial unload.
- Used in BIST wrappers: compacts WIDTH-bit response words into a signature, or free-runs as a pattern source.
- Flags pass/fail against an expected signature and shifts the result out serially.

Parameters:
- WIDTH, 16, signature/data width; legal range ≥ 2.
- POLY, 16'h1021, feedback tap mask. Bit i set means the feedback is XORed into bit i. The x^WIDTH term is implicit.
- CNT_W, 16, width of the cycle counter and of num_cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: synchronous, active-low.
- start  in  1  begin a run; sampled in IDLE or DONE only.
- mode  in  1  0 = MISR compaction (uses d_in, advances on d_valid); 1 = LFSR free-run (ignores d_in/d_valid, advances every cycle). Sampled at start.
- seed  in  WIDTH  initial signature; sampled at start.
- num_cycles  in  CNT_W  number of signature updates; sampled at start.
- exp_sig  in  WIDTH  expected final signature; sampled at start.
- d_valid  in  1  data qualifier in mode 0.
- d_in  in  WIDTH  response word.
- unload  in  1  request serial shift-out; honoured in DONE only.
- sig  out  WIDTH  current signature register (registered).
- busy  out  1  high in RUN or SHIFT (decoded from state).
- done  out  1  level; high in DONE.
- pass  out  1  registered compare result; valid while done=1.
- so  out  1  serial output, MSB first (registered).

Behaviour:
- Update function:
  - fb = sig[WIDTH-1].
  - next = {sig[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0) ^ (mode_q==0 ? d_in : 0).
- Reset (rst=0 at an edge): state=IDLE, sig=0, cnt=0, done=0, pass=0, so=0, latched mode/exp=0. Reset overrides everything, including mid-RUN or mid-SHIFT.
- States: IDLE, RUN, DONE, SHIFT.
- IDLE/DONE with start=1:
  - Loads sig<=seed, cnt<=num_cycles, mode_q<=mode, exp_q<=exp_sig.
  - Clears done and pass, then goes to RUN.
  - start has priority over unload in DONE.
- RUN, advance condition = (mode_q==1) or d_valid:
  - cnt==0: go to DONE, done<=1, pass<=(sig==exp_q). sig is unchanged (zero-length run, sig=seed).
  - advance and cnt≥1: sig<=next, cnt<=cnt-1.
  - If cnt==1 at that edge: go to DONE, done<=1, pass<=(next==exp_q).
  - No advance: sig and cnt hold. Gaps in d_valid do not change the final signature.
  - start during RUN is ignored.
- Latency: done rises on the edge of the num_cycles-th advance. With no gaps, that is num_cycles edges after the start edge.
- DONE with unload=1 (start=0):
  - Goes to SHIFT with a counter of WIDTH.
  - Each SHIFT edge: so<=sig[WIDTH-1], sig<={sig[WIDTH-2:0],1'b0}.
  - After WIDTH edges, returns to DONE.
  - pass is retained; sig reads 0 afterwards.
  - start and unload are ignored in SHIFT.
- so holds its last value outside SHIFT.
- Counter arithmetic is unsigned CNT_W bits with no wrap: it never decrements below 0.

Test Plan:
- Directed scenarios use WIDTH=4, POLY=4'b0011, CNT_W=8.
- LFSR period: mode=1, seed=0001, num_cycles=15, exp_sig=0001. Required:
  - sig sequence 0010, 0100, 1000, 0011, 0110, 1100, 1011, … back to 0001 on the 15th edge.
  - done=1 and pass=1 on that edge.
- MISR compaction: mode=0, seed=0000, d_in=0011 with d_valid=1, num_cycles=3, exp_sig=1001. Required:
  - sig goes 0011 → 0101 → 1001.
  - done=1, pass=1; busy=0 after.
- Valid gaps plus fail: repeat the compaction with d_valid toggling 1,0,0,1,0,1 and exp_sig=1000. Required:
  - Final sig=1001, reached 6 edges after start.
  - pass=0.
- Serial unload: from DONE with sig=1001, pulse unload. Required:
  - so=1,0,0,1 on 4 consecutive edges and busy=1 during SHIFT.
  - Then DONE, sig=0000, pass unchanged.
- Zero count and restart: num_cycles=0, seed=0101, exp_sig=0101. Required:
  - done=1, pass=1, sig=0101 one edge after RUN entry.
  - A start asserted in the same cycle as unload restarts the run (done cleared).
- Reset mid-run: drop rst for one edge during RUN with cnt=2. Required:
  - Next cycle sig=0, done=0, pass=0, busy=0, state IDLE.
  - start in RUN is demonstrably ignored before the reset.
